// File: rtl/sram_sprite_reader.sv
// sram_sprite_reader: read-side master for a 1-cycle registered-read sprite RAM.
// It turns sprite-relative (base, x, y) requests into RAM reads and returns the
// pixel words in acceptance order through a small response FIFO.
// Optional feature macro: SPRITE_KEY_EN adds the rsp_transp output, which flags
// words that equal KEY_COLOR.
module sram_sprite_reader #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    COORD_WIDTH = 6,
   parameter int                    SPRITE_W    = 32,
   parameter int                    SPRITE_H    = 32,
   parameter int                    FIFO_DEPTH  = 4,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR   = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_WIDTH-1:0]  req_base,
   input  logic [COORD_WIDTH-1:0] req_x,
   input  logic [COORD_WIDTH-1:0] req_y,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_data,
   output logic                   rsp_oob,
`ifdef SPRITE_KEY_EN
   output logic                   rsp_transp,
`endif
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   input  logic [DATA_WIDTH-1:0]  ram_rdata
);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PW + 1;

   logic                  ram_en_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic                  oob1_q, v2_q, oob2_q;
   logic [CNT_W-1:0]      out_q, out_d, cnt_q, cnt_d;
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic                  fifo_oob  [FIFO_DEPTH];
   logic                  v1_q;
   logic                  accept, pop, push, req_oob;
   logic [ADDR_WIDTH-1:0] addr_calc;
   logic [DATA_WIDTH-1:0] push_data;

   // Address arithmetic modulo 2^ADDR_WIDTH equals full-precision math truncated.
   assign addr_calc = req_base + ADDR_WIDTH'(req_y) * ADDR_WIDTH'(SPRITE_W) + ADDR_WIDTH'(req_x);
   assign req_oob   = (32'(req_x) >= SPRITE_W) || (32'(req_y) >= SPRITE_H);

   // The outstanding counter covers S1, S2 and the FIFO, so the FIFO can never overflow.
   assign req_ready = !reset && (out_q < CNT_W'(FIFO_DEPTH));
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (cnt_q != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign push      = v2_q;
   assign push_data = oob2_q ? '0 : ram_rdata;

   assign ram_en    = ram_en_q;
   assign ram_we    = 1'b0;
   assign ram_addr  = ram_addr_q;
   // Outputs read as zero while empty, which also gives the reset values.
   assign rsp_data  = rsp_valid ? fifo_data[rptr_q] : '0;
   assign rsp_oob   = rsp_valid && fifo_oob[rptr_q];

   // Next-state for the outstanding and FIFO occupancy counters.
   always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      case ({accept, pop})
         2'b10:   out_d = out_q + CNT_W'(1);
         2'b01:   out_d = out_q - CNT_W'(1);
         default: out_d = out_q;
      endcase
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Read pipeline tags, RAM command registers, FIFO pointers and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_en_q   <= 1'b0;
         ram_addr_q <= '0;
         v1_q       <= 1'b0;
         oob1_q     <= 1'b0;
         v2_q       <= 1'b0;
         oob2_q     <= 1'b0;
         out_q      <= '0;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         ram_en_q <= accept && !req_oob;
         // Out-of-bounds slots issue no read, so the address holds like an idle cycle.
         if (accept && !req_oob) ram_addr_q <= addr_calc;
         v1_q   <= accept;
         oob1_q <= req_oob;
         v2_q   <= v1_q;
         oob2_q <= oob1_q;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
      end
   end

   // FIFO storage; the S2 tag marks the one cycle the RAM output is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wptr_q] <= push_data;
         fifo_oob[wptr_q]  <= oob2_q;
      end
   end

`ifdef SPRITE_KEY_EN
   logic fifo_transp [FIFO_DEPTH];

   // Transparency is decided once at FIFO write; oob words are never transparent.
   always_ff @(posedge clk) begin
      if (push) fifo_transp[wptr_q] <= !oob2_q && (ram_rdata == KEY_COLOR);
   end

   assign rsp_transp = rsp_valid && fifo_transp[rptr_q];
`else
   logic unused_key;
   assign unused_key = ^KEY_COLOR;
`endif
endmodule

// File: tb/tb_sram_sprite_reader.sv
// Bench for sram_sprite_reader: queue-based reference model, directed and random stimulus.
module tb_sram_sprite_reader;
   localparam int DW = 8, AW = 16, CW = 6, SW = 32, SH = 32, DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_oob;
   logic [AW-1:0] req_base, ram_addr;
   logic [CW-1:0] req_x, req_y;
   logic [DW-1:0] rsp_data, ram_rdata;
   logic          ram_en, ram_we;
`ifdef SPRITE_KEY_EN
   logic          rsp_transp;
`endif

   always #5 clk = ~clk;

   sram_sprite_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COORD_WIDTH(CW),
                        .SPRITE_W(SW), .SPRITE_H(SH), .FIFO_DEPTH(DEPTH), .KEY_COLOR(8'h00)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base), .req_x(req_x), .req_y(req_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_oob(rsp_oob),
`ifdef SPRITE_KEY_EN
      .rsp_transp(rsp_transp),
`endif
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_rdata(ram_rdata));

   // RAM model: registered read, garbage on the output when not enabled.
   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) ram_rdata <= ram_en ? mem[ram_addr] : DW'($urandom);

   typedef struct {logic [AW-1:0] base; logic [CW-1:0] x; logic [CW-1:0] y;} req_t;
   typedef struct {logic [DW-1:0] data; logic oob; logic [AW-1:0] addr; int acc;} exp_t;

   req_t          pend[$];
   exp_t          expq[$];
   int            cyc = 0, n_chk = 0, n_pass = 0, n_fail = 0, n_acc = 0;
   logic          exp_en = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] last_pop = '0;
   logic          last_pop_oob = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Reference: the address and bounds rules in plain integer arithmetic.
   function automatic exp_t model(input req_t r, input int acc);
      exp_t e;
      int   full;
      full   = int'(r.base) + int'(r.y) * SW + int'(r.x);
      e.addr = full[AW-1:0];
      e.oob  = (int'(r.x) >= SW) || (int'(r.y) >= SH);
      e.data = e.oob ? '0 : mem[e.addr];
      e.acc  = acc;
      return e;
   endfunction

   function automatic req_t mk(input int base, input int x, input int y);
      req_t r;
      r.base = base[AW-1:0]; r.x = x[CW-1:0]; r.y = y[CW-1:0];
      return r;
   endfunction

   // One clock: drive at negedge, check outputs, then advance the model at posedge.
   task automatic tick();
      exp_t e;
      logic acc, pop, exp_rv;
      req_valid = (pend.size() > 0);
      if (req_valid) begin
         req_base = pend[0].base; req_x = pend[0].x; req_y = pend[0].y;
      end
      #1;
      chk("req_ready", 32'(req_ready), 32'(!reset && expq.size() < DEPTH));
      exp_rv = (expq.size() > 0) && (cyc - expq[0].acc >= 3);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         chk("rsp_data", 32'(rsp_data), 32'(expq[0].data));
         chk("rsp_oob", 32'(rsp_oob), 32'(expq[0].oob));
`ifdef SPRITE_KEY_EN
         chk("rsp_transp", 32'(rsp_transp), 32'(!expq[0].oob && expq[0].data == 8'h00));
`endif
      end
      chk("ram_en", 32'(ram_en), 32'(exp_en));
      chk("ram_addr", 32'(ram_addr), 32'(last_addr));
      chk("ram_we", 32'(ram_we), 32'(0));
      acc = req_valid && req_ready;
      pop = rsp_valid && rsp_ready;
      if (pop) begin last_pop = rsp_data; last_pop_oob = rsp_oob; end
      @(posedge clk);
      exp_en = 1'b0;
      if (pop && expq.size() > 0) void'(expq.pop_front());
      if (acc) begin
         e = model(pend[0], cyc);
         expq.push_back(e);
         if (!e.oob) begin exp_en = 1'b1; last_addr = e.addr; end
         void'(pend.pop_front());
         n_acc++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
      mem[16'h0123] = 8'hA5;
      mem[16'h000F] = 8'h3C;
      mem[16'h0200] = 8'h00;
      mem[16'h0201] = 8'h11;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_base = '0; req_x = '0; req_y = '0;
      @(negedge clk);
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'(0));
      chk("reset_rsp_data", 32'(rsp_data), 32'(0));
      chk("reset_rsp_oob", 32'(rsp_oob), 32'(0));
`ifdef SPRITE_KEY_EN
      chk("reset_rsp_transp", 32'(rsp_transp), 32'(0));
`endif
      @(negedge clk);
      ticks(2);
      reset = 1'b0;
      ticks(2);

      // 1: single read with exact latency
      pend.push_back(mk(16'h0100, 3, 1));
      ticks(6);
      chk("t1_data", 32'(last_pop), 32'(8'hA5));
      chk("t1_oob", 32'(last_pop_oob), 32'(0));

      // 2: 64 back-to-back requests with the consumer always ready
      n_acc = 0;
      for (int i = 0; i < 64; i++)
         pend.push_back(mk(int'($urandom), $urandom_range(0, 36), $urandom_range(0, 36)));
      ticks(64);
      chk("t2_accepted", 32'(n_acc), 32'(64));
      ticks(5);

      // 3: backpressure caps acceptance at the FIFO depth
      rsp_ready = 1'b0; n_acc = 0;
      for (int i = 0; i < 6; i++) pend.push_back(mk(16'h0300 + i, i, 2));
      ticks(8);
      chk("t3_accepted", 32'(n_acc), 32'(4));
      rsp_ready = 1'b1;
      ticks(12);
      chk("t3_all_accepted", 32'(n_acc), 32'(6));

      // 4: out-of-bounds column and address wrap
      pend.push_back(mk(16'h0100, 32, 0));
      pend.push_back(mk(16'hFFF0, 31, 0));
      ticks(2);
      chk("t4_wrap_addr", 32'(ram_addr), 32'(16'h000F));
      ticks(4);
      chk("t4_wrap_data", 32'(last_pop), 32'(8'h3C));

      // 5: reset with three requests outstanding
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) pend.push_back(mk(16'h0400, i, 0));
      ticks(6);
      reset = 1'b1;
      #1;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("t5_ram_en", 32'(ram_en), 32'(0));
      chk("t5_ram_addr", 32'(ram_addr), 32'(0));
      expq.delete(); pend.delete(); exp_en = 1'b0; last_addr = '0;
      @(negedge clk);
      ticks(2);
      reset = 1'b0;
      ticks(6);
      n_acc = 0;
      for (int i = 0; i < 5; i++) pend.push_back(mk(16'h0500, i, 3));
      ticks(8);
      chk("t5_restart_accepted", 32'(n_acc), 32'(4));
      rsp_ready = 1'b1;
      ticks(10);

`ifdef SPRITE_KEY_EN
      // 6: colour key
      pend.push_back(mk(16'h0200, 0, 0));
      pend.push_back(mk(16'h0200, 1, 0));
      pend.push_back(mk(16'h0200, 40, 0));
      ticks(8);
`endif

      // Random traffic with random consumer stalls
      for (int i = 0; i < 200; i++) begin
         if (pend.size() < 3 && $urandom_range(0, 3) != 0)
            pend.push_back(mk(int'($urandom), $urandom_range(0, 36), $urandom_range(0, 36)));
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      rsp_ready = 1'b1;
      ticks(12);
      chk("drain_empty", 32'(expq.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
